// File: rtl/ft245_dir_arbiter_if.sv
// ---------------------------------------------------------------------------
// ft245_dir_arbiter_if
// Groups the FT2232H handshake flags, the FIFO A/B flags and strobes, and the
// arbiter status outputs into one bundle.
//   master : drives en, rxf_n, txe_n, ffa, efb; observes everything else
//   slave  : the arbiter side (takes the flags, drives bus controls/status)
// Signals:
//   en        arbiter enable
//   rxf_n     FT2232H RXF#, low = USB data available
//   txe_n     FT2232H TXE#, low = room to transmit
//   ffa       FIFO A full
//   efb       FIFO B empty (first-word-fall-through)
//   oe_n      FT2232H OE#
//   rd_n      FT2232H RD#
//   wr_n      FT2232H WR#
//   drv       FPGA drives the shared data bus (1 = output)
//   wa        FIFO A write strobe
//   rb        FIFO B read strobe
//   busy      arbiter not idle
//   last_dir  direction of last granted burst (0 = RX, 1 = TX)
//   xfer_cnt  transfers done in the current/last burst
// ---------------------------------------------------------------------------
interface ft245_dir_arbiter_if #(
  parameter int CNT_W = 7
);
  logic             en;
  logic             rxf_n;
  logic             txe_n;
  logic             ffa;
  logic             efb;
  logic             oe_n;
  logic             rd_n;
  logic             wr_n;
  logic             drv;
  logic             wa;
  logic             rb;
  logic             busy;
  logic             last_dir;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output en, rxf_n, txe_n, ffa, efb,
    input  oe_n, rd_n, wr_n, drv, wa, rb, busy, last_dir, xfer_cnt
  );

  modport slave (
    input  en, rxf_n, txe_n, ffa, efb,
    output oe_n, rd_n, wr_n, drv, wa, rb, busy, last_dir, xfer_cnt
  );
endinterface

// File: rtl/ft245_dir_arbiter.sv
// ---------------------------------------------------------------------------
// ft245_dir_arbiter
// Shares the single bidirectional FT2232H data bus between the RX path
// (USB host -> FIFO A) and the TX path (FIFO B -> USB host). Grants the bus
// in bursts of at most BURST_MAX transfers, alternates direction when both
// sides request, and inserts TURN_CYC idle cycles after every burst so the
// bus driver can turn around.
// Ports:
//   clk    FT2232H CLKOUT, single clock domain
//   rst_n  asynchronous active-low reset
//   bus    ft245_dir_arbiter_if.slave (flags in; RD#/OE#/WR#, drv,
//          FIFO strobes and status out)
// Parameters:
//   BURST_MAX  max transfers per grant (>= 2)
//   CNT_W      burst counter width, 2**CNT_W > BURST_MAX
//   TURN_CYC   idle cycles after every burst (>= 1)
// ---------------------------------------------------------------------------
module ft245_dir_arbiter #(
  parameter int BURST_MAX = 64,
  parameter int CNT_W     = 7,
  parameter int TURN_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ft245_dir_arbiter_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX_OE  = 3'd1;
  localparam logic [2:0] S_RX     = 3'd2;
  localparam logic [2:0] S_TX_DRV = 3'd3;
  localparam logic [2:0] S_TX     = 3'd4;
  localparam logic [2:0] S_TURN   = 3'd5;

  localparam int               TURN_W    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_MAX - 1);

  logic [2:0]        state;
  logic              last_dir;
  logic [CNT_W-1:0]  xfer_cnt;
  logic [TURN_W-1:0] turn_cnt;

  logic rx_req;
  logic tx_req;
  logic wa;
  logic rb;

  assign rx_req = !bus.rxf_n && !bus.ffa;
  assign tx_req = !bus.txe_n && !bus.efb;

  // Strobes are combinational from the flags so they drop in the very cycle
  // a FIFO flag rises or the FT2232H withdraws RXF#/TXE#. They are not gated
  // by en: the transfer in the exit cycle still completes.
  assign wa = (state == S_RX) && rx_req;
  assign rb = (state == S_TX) && tx_req;

  assign bus.wa       = wa;
  assign bus.rb       = rb;
  assign bus.rd_n     = !wa;
  assign bus.wr_n     = !rb;
  // OE# and drv are pure state decodes, so they can never overlap.
  assign bus.oe_n     = !((state == S_RX_OE) || (state == S_RX));
  assign bus.drv      = (state == S_TX_DRV) || (state == S_TX);
  assign bus.busy     = (state != S_IDLE);
  assign bus.last_dir = last_dir;
  assign bus.xfer_cnt = xfer_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      last_dir <= 1'b1;  // RX wins the first contested grant
      xfer_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.en) begin
            // Contested grant goes to the direction not served last time.
            if (rx_req && (!tx_req || last_dir)) begin
              state    <= S_RX_OE;
              last_dir <= 1'b0;
              xfer_cnt <= '0;
            end else if (tx_req) begin
              state    <= S_TX_DRV;
              last_dir <= 1'b1;
              xfer_cnt <= '0;
            end
          end
        end

        S_RX_OE:  state <= S_RX;

        S_RX: begin
          if (wa) xfer_cnt <= xfer_cnt + CNT_W'(1);
          if ((wa && (xfer_cnt == CNT_LAST)) || bus.rxf_n || bus.ffa || !bus.en) begin
            state    <= S_TURN;
            turn_cnt <= '0;
          end
        end

        S_TX_DRV: state <= S_TX;

        S_TX: begin
          if (rb) xfer_cnt <= xfer_cnt + CNT_W'(1);
          if ((rb && (xfer_cnt == CNT_LAST)) || bus.txe_n || bus.efb || !bus.en) begin
            state    <= S_TURN;
            turn_cnt <= '0;
          end
        end

        S_TURN: begin
          if (turn_cnt == TURN_LAST) state    <= S_IDLE;
          else                       turn_cnt <= turn_cnt + TURN_W'(1);
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
